// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared FSM type and bus constants for the Avalon burst reader
package avalon_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} burst_reader_state_t;

  localparam int         AVALON_DATA_W = 32;
  localparam logic [3:0] AVALON_BE_ALL = 4'hF;

endpackage

// File: rtl/avalon_if.sv
// rtl/avalon_if.sv - Avalon-MM bus bundle with host and agent views
interface avalon_if #(
  parameter int BURSTCOUNT_W = 4
) (
  input logic clk
);

  logic [31:0]             address;
  logic                    read;
  logic                    write;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic [3:0]              byteenable;
  logic                    waitrequest;
  logic [31:0]             readdata;
  logic                    readdatavalid;

  modport host (
    input  clk, waitrequest, readdata, readdatavalid,
    output address, read, write, burstcount, byteenable
  );

  modport agent (
    input  clk, address, read, write, burstcount, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and zeroed output when empty
module sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == DEPTH);
  assign count  = r_count;
  assign w_pop  = pop && !empty;
  // a full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign w_push = push && (!full || w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  // storage array; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // upstream space reservation must make a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/avalon_burst_reader.sv
// rtl/avalon_burst_reader.sv - Avalon-MM burst-read host feeding a stream FIFO (optional AVALON_BURST_READER_STATS_EN)
module avalon_burst_reader
  import avalon_pkg::*;
#(
  parameter int BURSTCOUNT_W = 4,
  parameter int FIFO_AW      = 4,
  parameter int LEN_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  input  logic [LEN_W-1:0]         length,
  output logic                     busy,
  output logic                     done,
  output logic [AVALON_DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef AVALON_BURST_READER_STATS_EN
  output logic [15:0]              stat_bursts,
  output logic [15:0]              stat_wait_cycles,
`endif
  avalon_if.host                   avalon_h
);

  localparam int                MAX_BURST  = 2 ** (BURSTCOUNT_W - 1);
  localparam logic [FIFO_AW:0]  FIFO_DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);
  localparam logic [FIFO_AW:0]  COUNT_ONE  = (FIFO_AW + 1)'(1);

  burst_reader_state_t r_state, w_state_nxt;

  logic [29:0]             r_waddr, w_waddr_nxt;
  logic [LEN_W-1:0]        r_remaining, w_remaining_nxt;
  logic [BURSTCOUNT_W-1:0] r_beats, w_beats_nxt;
  logic                    r_read, w_read_nxt;
  logic [31:0]             r_addr, w_addr_nxt;
  logic [BURSTCOUNT_W-1:0] r_burstcount, w_burstcount_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_start_acc;

  logic                    w_push, w_pop, w_empty, w_full;
  logic [FIFO_AW:0]        w_count, w_free;
  logic [BURSTCOUNT_W-1:0] w_bsz;
  logic                    w_space_ok;
  logic                    w_unused;

  function automatic logic [BURSTCOUNT_W-1:0] f_bsz(input logic [LEN_W-1:0] rem);
    if (rem < LEN_W'(MAX_BURST)) return BURSTCOUNT_W'(rem);
    return BURSTCOUNT_W'(MAX_BURST);
  endfunction

  assign w_push     = (r_state == DATA) && avalon_h.readdatavalid;
  assign w_pop      = out_valid && out_ready;
  assign w_free     = FIFO_DEPTH - w_count;
  // in IDLE the next burst is sized from the incoming length, otherwise from what is left
  assign w_bsz      = (r_state == IDLE) ? f_bsz(length) : f_bsz(r_remaining);
  assign w_space_ok = 32'(w_bsz) <= 32'(w_free);
  assign w_unused   = ^{base_addr[1:0], w_full};

  sync_fifo #(
    .DW (AVALON_DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (avalon_h.readdata),
    .dout  (out_data),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  // next-state and next-register values for the burst sequencer
  always_comb begin
    w_state_nxt      = r_state;
    w_waddr_nxt      = r_waddr;
    w_remaining_nxt  = r_remaining;
    w_beats_nxt      = r_beats;
    w_read_nxt       = r_read;
    w_addr_nxt       = r_addr;
    w_burstcount_nxt = r_burstcount;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_start_acc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc     = 1'b1;
          w_busy_nxt      = 1'b1;
          w_waddr_nxt     = base_addr[31:2];
          w_remaining_nxt = length;
          if (length == '0) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = REQ;
            if (w_space_ok) begin
              w_read_nxt       = 1'b1;
              w_addr_nxt       = {base_addr[31:2], 2'b00};
              w_burstcount_nxt = w_bsz;
              w_beats_nxt      = w_bsz;
            end
          end
        end
      end
      REQ: begin
        if (!r_read) begin
          if (w_space_ok) begin
            w_read_nxt       = 1'b1;
            w_addr_nxt       = {r_waddr, 2'b00};
            w_burstcount_nxt = w_bsz;
            w_beats_nxt      = w_bsz;
          end
        end else if (!avalon_h.waitrequest) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (avalon_h.readdatavalid) begin
          w_beats_nxt = r_beats - 1'b1;
          if (r_beats == BURSTCOUNT_W'(1)) begin
            w_remaining_nxt = r_remaining - LEN_W'(r_burstcount);
            w_waddr_nxt     = r_waddr + 30'(r_burstcount);
            w_state_nxt     = (w_remaining_nxt == '0) ? FIN : REQ;
          end
        end
      end
      FIN: begin
        // look one pop ahead so done lands in the cycle right after the last word leaves
        if (w_count == '0 || (w_count == COUNT_ONE && w_pop)) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // registered bus request, transfer bookkeeping and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_waddr      <= '0;
      r_remaining  <= '0;
      r_beats      <= '0;
      r_read       <= 1'b0;
      r_addr       <= '0;
      r_burstcount <= BURSTCOUNT_W'(1);
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_waddr      <= w_waddr_nxt;
      r_remaining  <= w_remaining_nxt;
      r_beats      <= w_beats_nxt;
      r_read       <= w_read_nxt;
      r_addr       <= w_addr_nxt;
      r_burstcount <= w_burstcount_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

`ifdef AVALON_BURST_READER_STATS_EN
  logic [15:0] r_stat_bursts;
  logic [15:0] r_stat_wait;

  // saturating counters of accepted bursts and bus wait cycles, cleared per transfer
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_stat_bursts <= '0;
      r_stat_wait   <= '0;
    end else begin
      if (r_read && !avalon_h.waitrequest && r_stat_bursts != 16'hFFFF)
        r_stat_bursts <= r_stat_bursts + 16'd1;
      if (r_read && avalon_h.waitrequest && r_stat_wait != 16'hFFFF)
        r_stat_wait <= r_stat_wait + 16'd1;
    end
  end

  assign stat_bursts      = r_stat_bursts;
  assign stat_wait_cycles = r_stat_wait;
`endif

  assign avalon_h.read       = r_read;
  assign avalon_h.write      = 1'b0;
  assign avalon_h.address    = r_addr;
  assign avalon_h.burstcount = r_burstcount;
  assign avalon_h.byteenable = AVALON_BE_ALL;
  assign busy                = r_busy;
  assign done                = r_done;
  assign out_valid           = !w_empty;

endmodule

// File: tb/tb_avalon_burst_reader.sv
// tb/tb_avalon_burst_reader.sv - self-checking bench for avalon_burst_reader with a behavioural memory agent
`timescale 1ns/1ps
module tb_avalon_burst_reader;

  localparam int BCW  = 4;
  localparam int FAW  = 4;
  localparam int LW   = 16;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef AVALON_BURST_READER_STATS_EN
  logic [15:0]   stat_bursts;
  logic [15:0]   stat_wait_cycles;
`endif

  always #5 clk = ~clk;

  avalon_if #(.BURSTCOUNT_W(BCW)) bus (.clk(clk));

  avalon_burst_reader #(
    .BURSTCOUNT_W (BCW),
    .FIFO_AW      (FAW),
    .LEN_W        (LW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
`ifdef AVALON_BURST_READER_STATS_EN
    .stat_bursts      (stat_bursts),
    .stat_wait_cycles (stat_wait_cycles),
`endif
    .avalon_h         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } burst_t;

  // memory agent state
  int unsigned ag_stall_cfg = 0;
  bit          ag_gaps      = 1'b0;
  logic [31:0] mem_seed     = 32'd0;
  int unsigned ag_wcnt      = 0;
  int unsigned ag_beats     = 0;
  logic [29:0] ag_waddr     = '0;
  int          proto_err    = 0;
  logic        prev_hold    = 1'b0;
  logic [31:0] prev_addr    = '0;
  logic [BCW-1:0] prev_cnt  = '0;
  burst_t      b_log[$];

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return 32'(w) - 32'd63 + mem_seed;
  endfunction

  assign bus.waitrequest = bus.read && (ag_wcnt < ag_stall_cfg);

  always @(posedge clk) begin
    bus.readdatavalid <= 1'b0;
    if (prev_hold && (bus.read !== 1'b1 || bus.address !== prev_addr || bus.burstcount !== prev_cnt))
      proto_err++;
    if (!reset && (bus.write !== 1'b0 || bus.byteenable !== 4'hF))
      proto_err++;
    prev_hold <= bus.read && bus.waitrequest && !reset;
    prev_addr <= bus.address;
    prev_cnt  <= bus.burstcount;
    if (reset) begin
      ag_wcnt <= 0;
    end else if (bus.read === 1'b1 && bus.waitrequest) begin
      ag_wcnt <= ag_wcnt + 1;
    end else if (bus.read === 1'b1) begin
      ag_wcnt <= 0;
      if (ag_beats != 0) proto_err++;
      b_log.push_back('{bus.address, int'(bus.burstcount)});
      ag_beats <= int'(bus.burstcount);
      ag_waddr <= bus.address[31:2];
    end
    if (ag_beats != 0 && (!ag_gaps || $urandom_range(0, 3) != 0)) begin
      bus.readdatavalid <= 1'b1;
      bus.readdata      <= mem_word(ag_waddr);
      ag_waddr          <= ag_waddr + 30'd1;
      ag_beats          <= ag_beats - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":read"},       bus.read,       1'b0);
    check({tag, ":write"},      bus.write,      1'b0);
    check({tag, ":burstcount"}, bus.burstcount, 1);
    check({tag, ":address"},    bus.address,    0);
    check({tag, ":byteenable"}, bus.byteenable, 4'hF);
    check({tag, ":busy"},       busy,           1'b0);
    check({tag, ":done"},       done,           1'b0);
    check({tag, ":out_valid"},  out_valid,      1'b0);
    check({tag, ":out_data"},   out_data,       0);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input int len,
                          input int ready_pct, input int hold_off, input int restart_at,
                          input bit bp_check);
    logic [31:0] exp_q[$];
    burst_t      exp_b[$];
    logic [31:0] a;
    int          rem;
    int          b0;
    int          got;
    int          cyc;
    int          nb;
    bit          fin;
    a   = {base[31:2], 2'b00};
    rem = len;
    b0  = b_log.size();
    got = 0;
    cyc = 0;
    fin = 1'b0;
    for (int i = 0; i < len; i++) exp_q.push_back(mem_word(base[31:2] + 30'(i)));
    while (rem > 0) begin
      int c;
      c = (rem < MAXB) ? rem : MAXB;
      exp_b.push_back('{a, c});
      a   = a + 32'(4 * c);
      rem = rem - c;
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    length    = LW'(len);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy_rise"}, busy, 1'b1);
    check({tag, ":done_early"}, done, 1'b0);
    if (len > 0) check({tag, ":read_rise"}, bus.read, 1'b1);
    @(negedge clk);

    while (!fin && cyc < 4000) begin
      out_ready = (cyc >= hold_off) && ($urandom_range(1, 100) <= ready_pct);
      if (cyc == restart_at) begin
        start     = 1'b1;
        base_addr = 32'h0000_0200;
        length    = LW'(5);
      end else begin
        start = 1'b0;
      end
      if (bp_check && cyc == hold_off - 1) begin
        check({tag, ":bursts_while_stalled"}, b_log.size() - b0, 2);
        check({tag, ":fifo_full_level"}, dut.u_fifo.count, 16);
        check({tag, ":valid_while_stalled"}, out_valid, 1'b1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check({tag, ":extra_word"}, got, len);
        else                   check({tag, ":data"}, out_data, exp_q.pop_front());
        got++;
      end
      if (done) begin
        fin = 1'b1;
        check({tag, ":busy_at_done"}, busy, 1'b0);
        check({tag, ":words_at_done"}, got, len);
        if (len == 0) check({tag, ":len0_latency"}, cyc, 0);
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    if (!fin) check({tag, ":timeout"}, 0, 1);
    check({tag, ":done_single"}, done, 1'b0);
    check({tag, ":busy_after"}, busy, 1'b0);
    nb = b_log.size() - b0;
    check({tag, ":nbursts"}, nb, exp_b.size());
    for (int i = 0; i < exp_b.size() && i < nb; i++) begin
      check({tag, ":burst_addr"}, b_log[b0 + i].addr, exp_b[i].addr);
      check({tag, ":burst_cnt"},  b_log[b0 + i].cnt,  exp_b[i].cnt);
    end
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run_xfer("single", 32'h0000_0100, 8, 100, 0, -1, 1'b0);
    run_xfer("multi", 32'h0000_0100, 19, 100, 0, -1, 1'b0);
    run_xfer("backpressure", 32'h0000_0100, 32, 100, 39, -1, 1'b1);

    ag_stall_cfg = 5;
    run_xfer("stall", 32'h0000_0100, 8, 100, 0, -1, 1'b0);
`ifdef AVALON_BURST_READER_STATS_EN
    check("stall:stat_wait_cycles", stat_wait_cycles, 5);
    check("stall:stat_bursts", stat_bursts, 1);
`endif
    ag_stall_cfg = 0;

    run_xfer("len0", 32'h0000_0100, 0, 100, 0, -1, 1'b0);
    run_xfer("start_while_busy", 32'h0000_0100, 19, 60, 0, 3, 1'b0);
    run_xfer("addr_wrap", 32'hFFFF_FFE2, 12, 100, 0, -1, 1'b0);

    // reset while beats are streaming in
    @(negedge clk);
    start     = 1'b1;
    base_addr = 32'h0000_0100;
    length    = LW'(16);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (bus.readdatavalid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("reset_mid:wait_data_timeout", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    reset = 1'b0;
    k = 0;
    while ((ag_beats != 0 || bus.readdatavalid === 1'b1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("reset_mid:drain_timeout", 0, 1);
    check("reset_mid:stale_beats_dropped", out_valid, 1'b0);
    check("reset_mid:idle_after", busy, 1'b0);
    run_xfer("after_reset", 32'h0000_0100, 10, 100, 0, -1, 1'b0);

    ag_gaps = 1'b1;
    for (int t = 0; t < 6; t++) begin
      mem_seed     = $urandom;
      ag_stall_cfg = $urandom_range(0, 3);
      run_xfer("random", $urandom, int'($urandom_range(1, 40)),
               int'($urandom_range(30, 100)), 0, -1, 1'b0);
    end

    check("protocol_errors", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avalon_burst_reader.md
# avalon_burst_reader

Avalon-MM host that fetches a contiguous block of 32-bit words from an Avalon memory agent using burst reads. It sits directly upstream of the BlockRAM agent on the same avalon_if and presents the fetched words, in address order, on a valid/ready stream output. It buffers the words in an internal FIFO and issues a burst only when the whole burst fits, so the stream consumer can stall freely without breaking the bus protocol.

## Interface
Parameters:
- BURSTCOUNT_W, 4: width of burstcount. The maximum burst is MAX_BURST = 2**(BURSTCOUNT_W-1) words.
- FIFO_AW, 4: FIFO depth is 2**FIFO_AW words. Must be at least MAX_BURST.
- LEN_W, 16: width of the length port.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, the same clock as avalon_h.clk.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request. Accepted only in IDLE.
- base_addr  in  32  byte address, word-aligned. Bits [1:0] are ignored.
- length  in  LEN_W  number of words to fetch.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- avalon_h  modport  avalon_if.host  drives address, read, burstcount, byteenable and write; samples waitrequest, readdata and readdatavalid.

## Operation
- States:
  - IDLE: on start, latch base_addr[31:2] and length, then go to REQ. If length == 0, go to FIN instead.
  - REQ: issue a burst when free FIFO slots ≥ bsz, where bsz = min(remaining, MAX_BURST). Hold read=1, address and burstcount=bsz until the cycle with read && !waitrequest, then go to DATA.
  - DATA: each readdatavalid pushes readdata into the FIFO and decrements the beat counter. After the last beat: remaining -= bsz and addr += 4*bsz. If remaining > 0, return to REQ; otherwise go to FIN.
  - FIN: wait until the FIFO is empty, then pulse done and return to IDLE.
- Only one burst is outstanding at a time. No new read is issued before the previous burst has fully returned.
- write is always 0 and byteenable is always 4'hF.
- The stream pops on out_valid && out_ready. out_valid = !fifo_empty.
- start while busy is ignored.
- A readdatavalid outside DATA is ignored and does not push.
- Arithmetic:
  - remaining is LEN_W bits.
  - address is 32 bits and wraps modulo 2**32.
  - burstcount is zero-extended from bsz.

## Timing
- Reset values: read=0, write=0, burstcount=1, address=0, byteenable=4'hF, busy=0, done=0, out_valid=0, out_data=0. The FIFO is flushed and the state is IDLE.
- start sampled at edge n gives busy=1 and read=1 from cycle n+1 if the FIFO has space.
- read, address and burstcount are registered and stable while waitrequest=1.
- A FIFO push is visible as out_valid in the cycle after readdatavalid (1-cycle FIFO latency).
- done is asserted in the cycle after the pop of the final word. busy falls in the same cycle as done.
- length == 0 gives done two cycles after start, with no bus activity.
- Simultaneous push and pop on a full FIFO is legal: the count is unchanged.
- The FIFO space reservation guarantees no push while full. The simulation assertion `push && full` must never fire.
- Reset mid-burst aborts immediately. Beats still arriving from the agent after reset are dropped.

## Configuration
- AVALON_BURST_READER_STATS_EN, when defined, adds two outputs:
  - stat_bursts[15:0] counts accepted bursts.
  - stat_wait_cycles[15:0] counts cycles with read && waitrequest.
- Both counters saturate at 16'hFFFF, clear on reset and clear on an accepted start.
- Without the macro, these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package avalon_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} burst_reader_state_t.
  - Constants AVALON_DATA_W = 32 and AVALON_BE_ALL = 4'hF.
- One sub-module, sync_fifo (parameters DW and AW):
  - Ports: push, pop, din, dout, empty, full, count.
  - Synchronous reset.
- The space check uses free slots = 2**FIFO_AW - count.

## Test plan
- Single burst: base_addr=0x100, length=8, memory preloaded with i+1 at word i. Expect one read with burstcount=8, address=0x100, then the stream delivers 1..8 followed by one done pulse.
- Multi-burst with tail: length=19. Expect bursts of 8, 8 and 3 at addresses 0x100, 0x120 and 0x140, and 19 words in order.
- Backpressure: length=32 with out_ready=0 for 40 cycles. Expect the FIFO to fill to 16 and at most two bursts issued before the stall releases, no overflow assertion, then all 32 words correct.
- waitrequest stall: agent holds waitrequest=1 for 5 cycles. Expect read, address and burstcount held constant, and with STATS_EN stat_wait_cycles=5.
- Boundaries: length=0 gives done with no read. start while busy is ignored (same word count). Reset asserted during DATA gives all outputs at reset values next cycle, and a new start completes correctly.
